// File: rtl/matrix_bank_pkg.sv
// Shared constants, types and helpers for the matrix storage bank.
package matrix_bank_pkg;

    localparam int                SLOT_WORDS    = 25;
    localparam int                MAX_SLOTS_DEF = 10;
    localparam int                SLOT_IDX_W    = 4;
    localparam int                ADDR_W        = 8;
    localparam logic [31:0]       DIM_MAX       = 32'd5;
    localparam int                AGE_W         = 4;
    localparam logic [AGE_W-1:0]  AGE_MAX       = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_DECIDE    = 3'd2,
        ST_COMMIT    = 3'd3,
        ST_WAIT_DROP = 3'd4
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [2:0]       m;
        logic [2:0]       n;
        logic [AGE_W-1:0] age;
    } slot_t;

    function automatic logic dim_legal(input logic [31:0] d);
        return (d >= 32'd1) && (d <= DIM_MAX);
    endfunction

    function automatic logic [ADDR_W-1:0] slot_base(input logic [SLOT_IDX_W-1:0] idx);
        return ADDR_W'(32'(idx) * SLOT_WORDS);
    endfunction

endpackage

// File: rtl/matrix_bank_ram.sv
// Simple dual-port element store: one write port, one registered read port.
// A read colliding with a write to the same address returns the old word.
module matrix_bank_ram #(
    parameter int DEPTH  = 250,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic              w_wr_ok;
    logic              w_rd_ok;

    assign w_wr_ok = i_wr_en && (32'(i_wr_addr) < 32'(DEPTH));
    assign w_rd_ok = (32'(i_rd_addr) < 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Out-of-range reads return zero rather than whatever the array holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (w_rd_ok) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/matrix_bank_mgr.sv
// Matrix slot allocator and element bank; optional lookup port under MATRIX_BANK_LOOKUP_EN.
//   state     | meaning
//   IDLE      | waiting for req_valid
//   SCAN      | walking the slot table, one slot per cycle
//   DECIDE    | choosing the victim slot
//   COMMIT    | writing the table entry, ageing the others
//   WAIT_DROP | holding until req_valid falls
module matrix_bank_mgr
    import matrix_bank_pkg::*;
#(
    parameter int MAX_SLOTS    = MAX_SLOTS_DEF,
    parameter int MATS_PER_DIM = 2,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    input  logic [31:0]       i_req_m,
    input  logic [31:0]       i_req_n,
    output logic              o_alloc_ready,
    output logic [7:0]        o_alloc_base,
    output logic              o_alloc_err,
    input  logic              i_wr_en,
    input  logic [7:0]        i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [7:0]        i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
`ifdef MATRIX_BANK_LOOKUP_EN
    input  logic [2:0]        i_q_m,
    input  logic [2:0]        i_q_n,
    input  logic              i_q_idx,
    output logic [7:0]        o_q_base,
    output logic              o_q_hit,
    output logic [1:0]        o_q_cnt,
`endif
    output logic [3:0]        o_live_cnt
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    slot_t                   r_slot [MAX_SLOTS];

    logic [2:0]              r_m;
    logic [2:0]              r_n;
    logic [SLOT_IDX_W-1:0]   r_idx;
    logic [SLOT_IDX_W-1:0]   r_match_cnt;
    logic                    r_match_found;
    logic [SLOT_IDX_W-1:0]   r_match_idx;
    logic [AGE_W-1:0]        r_match_age;
    logic                    r_free_found;
    logic [SLOT_IDX_W-1:0]   r_free_idx;
    logic                    r_old_found;
    logic [SLOT_IDX_W-1:0]   r_old_idx;
    logic [AGE_W-1:0]        r_old_age;
    logic [SLOT_IDX_W-1:0]   r_victim;

    logic                    r_alloc_ready;
    logic                    r_alloc_err;
    logic [7:0]              r_alloc_base;
    logic [3:0]              r_live_cnt;

    logic                    w_req_legal;
    logic                    w_start;
    logic                    w_err;
    logic                    w_scan_en;
    logic                    w_decide_en;
    logic                    w_commit_en;
    slot_t                   w_cur;
    logic                    w_cur_match;
    logic [SLOT_IDX_W-1:0]   w_victim;
    logic [3:0]              w_live_nxt;

    assign w_req_legal = dim_legal(i_req_m) && dim_legal(i_req_n);
    assign w_cur       = r_slot[r_idx];
    assign w_cur_match = w_cur.valid && (w_cur.m == r_m) && (w_cur.n == r_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_err       = 1'b0;
        w_scan_en   = 1'b0;
        w_decide_en = 1'b0;
        w_commit_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (w_req_legal) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_WAIT_DROP;
                    end
                end
            end
            ST_SCAN: begin
                w_scan_en = 1'b1;
                if (r_idx == SLOT_IDX_W'(MAX_SLOTS - 1)) begin
                    w_state_nxt = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                w_decide_en = 1'b1;
                w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_commit_en = 1'b1;
                w_state_nxt = ST_WAIT_DROP;
            end
            ST_WAIT_DROP: begin
                if (!i_req_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Scan accumulators; strict '>' keeps the lowest index on age ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m           <= '0;
            r_n           <= '0;
            r_idx         <= '0;
            r_match_cnt   <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_match_age   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_old_found   <= 1'b0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
        end else if (w_start) begin
            r_m           <= i_req_m[2:0];
            r_n           <= i_req_n[2:0];
            r_idx         <= '0;
            r_match_cnt   <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_match_age   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_old_found   <= 1'b0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
        end else if (w_scan_en) begin
            r_idx <= r_idx + 1'b1;
            if (w_cur.valid) begin
                if (!r_old_found || (w_cur.age > r_old_age)) begin
                    r_old_found <= 1'b1;
                    r_old_idx   <= r_idx;
                    r_old_age   <= w_cur.age;
                end
                if (w_cur_match) begin
                    r_match_cnt <= r_match_cnt + 1'b1;
                    if (!r_match_found || (w_cur.age > r_match_age)) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_idx;
                        r_match_age   <= w_cur.age;
                    end
                end
            end else if (!r_free_found) begin
                r_free_found <= 1'b1;
                r_free_idx   <= r_idx;
            end
        end
    end

    always_comb begin
        w_victim = r_old_idx;
        if (r_match_cnt >= SLOT_IDX_W'(MATS_PER_DIM)) begin
            w_victim = r_match_idx;
        end else if (r_free_found) begin
            w_victim = r_free_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_victim <= '0;
        end else if (w_decide_en) begin
            r_victim <= w_victim;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < MAX_SLOTS; s++) begin
                r_slot[s] <= '0;
            end
        end else if (w_commit_en) begin
            for (int s = 0; s < MAX_SLOTS; s++) begin
                if (SLOT_IDX_W'(s) == r_victim) begin
                    r_slot[s].valid <= 1'b1;
                    r_slot[s].m     <= r_m;
                    r_slot[s].n     <= r_n;
                    r_slot[s].age   <= '0;
                end else if (r_slot[s].valid && (r_slot[s].age != AGE_MAX)) begin
                    r_slot[s].age <= r_slot[s].age + 1'b1;
                end
            end
        end
    end

    // Slots never become invalid outside reset, so the new count is valid | victim.
    always_comb begin
        w_live_nxt = '0;
        for (int s = 0; s < MAX_SLOTS; s++) begin
            if (r_slot[s].valid || (SLOT_IDX_W'(s) == r_victim)) begin
                w_live_nxt = w_live_nxt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alloc_ready <= 1'b0;
            r_alloc_err   <= 1'b0;
            r_alloc_base  <= '0;
            r_live_cnt    <= '0;
        end else begin
            r_alloc_ready <= w_commit_en;
            r_alloc_err   <= w_err;
            if (w_commit_en) begin
                r_alloc_base <= slot_base(r_victim);
                r_live_cnt   <= w_live_nxt;
            end
        end
    end

    assign o_alloc_ready = r_alloc_ready;
    assign o_alloc_err   = r_alloc_err;
    assign o_alloc_base  = r_alloc_base;
    assign o_live_cnt    = r_live_cnt;

    matrix_bank_ram #(
        .DEPTH  (MAX_SLOTS * SLOT_WORDS),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

`ifdef MATRIX_BANK_LOOKUP_EN
    logic [MAX_SLOTS-1:0]  w_q_match;
    logic [3:0]            w_q_raw_cnt;
    logic                  w_y_found;
    logic [SLOT_IDX_W-1:0] w_y_idx;
    logic [AGE_W-1:0]      w_y_age;
    logic                  w_o_found;
    logic [SLOT_IDX_W-1:0] w_o_idx;
    logic [AGE_W-1:0]      w_o_age;
    logic                  w_q_hit;
    logic [7:0]            w_q_base;
    logic [1:0]            w_q_cnt;
    logic                  r_q_hit;
    logic [7:0]            r_q_base;
    logic [1:0]            r_q_cnt;

    // Youngest = minimum age; the older one is the oldest of the remaining matches.
    always_comb begin
        w_q_match   = '0;
        w_q_raw_cnt = '0;
        w_y_found   = 1'b0;
        w_y_idx     = '0;
        w_y_age     = '0;
        w_o_found   = 1'b0;
        w_o_idx     = '0;
        w_o_age     = '0;
        for (int s = 0; s < MAX_SLOTS; s++) begin
            w_q_match[s] = r_slot[s].valid && (r_slot[s].m == i_q_m) && (r_slot[s].n == i_q_n);
            if (w_q_match[s]) begin
                w_q_raw_cnt = w_q_raw_cnt + 1'b1;
                if (!w_y_found || (r_slot[s].age < w_y_age)) begin
                    w_y_found = 1'b1;
                    w_y_idx   = SLOT_IDX_W'(s);
                    w_y_age   = r_slot[s].age;
                end
            end
        end
        for (int s = 0; s < MAX_SLOTS; s++) begin
            if (w_q_match[s] && (SLOT_IDX_W'(s) != w_y_idx)) begin
                if (!w_o_found || (r_slot[s].age > w_o_age)) begin
                    w_o_found = 1'b1;
                    w_o_idx   = SLOT_IDX_W'(s);
                    w_o_age   = r_slot[s].age;
                end
            end
        end
        w_q_cnt  = (w_q_raw_cnt > 4'd3) ? 2'd3 : w_q_raw_cnt[1:0];
        w_q_hit  = i_q_idx ? w_o_found : w_y_found;
        w_q_base = '0;
        if (w_q_hit) begin
            w_q_base = slot_base(i_q_idx ? w_o_idx : w_y_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_hit  <= 1'b0;
            r_q_base <= '0;
            r_q_cnt  <= '0;
        end else begin
            r_q_hit  <= w_q_hit;
            r_q_base <= w_q_base;
            r_q_cnt  <= w_q_cnt;
        end
    end

    assign o_q_hit  = r_q_hit;
    assign o_q_base = r_q_base;
    assign o_q_cnt  = r_q_cnt;
`endif

endmodule

// File: tb/tb_matrix_bank_mgr.sv
// Directed self-checking bench for matrix_bank_mgr; lookup checks built only with MATRIX_BANK_LOOKUP_EN.
module tb_matrix_bank_mgr;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_m;
    logic [31:0] req_n;
    logic        alloc_ready;
    logic [7:0]  alloc_base;
    logic        alloc_err;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [3:0]  live_cnt;
`ifdef MATRIX_BANK_LOOKUP_EN
    logic [2:0]  q_m;
    logic [2:0]  q_n;
    logic        q_idx;
    logic [7:0]  q_base;
    logic        q_hit;
    logic [1:0]  q_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    matrix_bank_mgr dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid),
        .i_req_m       (req_m),
        .i_req_n       (req_n),
        .o_alloc_ready (alloc_ready),
        .o_alloc_base  (alloc_base),
        .o_alloc_err   (alloc_err),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
`ifdef MATRIX_BANK_LOOKUP_EN
        .i_q_m         (q_m),
        .i_q_n         (q_n),
        .i_q_idx       (q_idx),
        .o_q_base      (q_base),
        .o_q_hit       (q_hit),
        .o_q_cnt       (q_cnt),
`endif
        .o_live_cnt    (live_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Request, wait for the pulse (bounded), check latency and pulse width, then drop.
    task automatic do_alloc(input logic [31:0] m, input logic [31:0] n, input string tag,
                            output logic [7:0] base);
        int lat;
        bit got;
        @(negedge clk);
        req_valid = 1'b1;
        req_m     = m;
        req_n     = n;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (alloc_ready === 1'b1) got = 1'b1;
        end
        base = alloc_base;
        check({tag, " latency"}, 64'(lat), 64'd13);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, " pulse width"}, 64'(alloc_ready), 64'd0);
    endtask

    task automatic count_pulses(input int cycles, output int cnt, output logic [7:0] last_base);
        cnt = 0;
        last_base = '0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (alloc_ready === 1'b1) begin
                cnt++;
                last_base = alloc_base;
            end
        end
    endtask

    task automatic illegal_req(input logic [31:0] m, input logic [31:0] n, input string tag);
        int cnt;
        logic [7:0] b;
        @(negedge clk);
        req_valid = 1'b1;
        req_m     = m;
        req_n     = n;
        @(posedge clk); #1;
        check({tag, " err pulse"}, 64'(alloc_err), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, " err one cycle"}, 64'(alloc_err), 64'd0);
        count_pulses(16, cnt, b);
        check({tag, " no ready"}, 64'(cnt), 64'd0);
        check({tag, " live unchanged"}, 64'(live_cnt), 64'd2);
    endtask

    initial begin
        logic [7:0] base;
        int         cnt;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_m     = '0;
        req_n     = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
`ifdef MATRIX_BANK_LOOKUP_EN
        q_m   = '0;
        q_n   = '0;
        q_idx = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset alloc_ready", 64'(alloc_ready), 64'd0);
        check("reset alloc_err", 64'(alloc_err), 64'd0);
        check("reset alloc_base", 64'(alloc_base), 64'd0);
        check("reset live_cnt", 64'(live_cnt), 64'd0);
        check("reset rd_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Allocation of one (m,n) pair up to the per-dimension limit and reuse.
        do_alloc(32'd2, 32'd3, "t1 first", base);
        check("t1 first base", 64'(base), 64'd0);
        check("t1 first live", 64'(live_cnt), 64'd1);
        do_alloc(32'd2, 32'd3, "t1 second", base);
        check("t1 second base", 64'(base), 64'd25);
        check("t1 second live", 64'(live_cnt), 64'd2);
        do_alloc(32'd2, 32'd3, "t1 third", base);
        check("t1 third base", 64'(base), 64'd0);
        check("t1 third live", 64'(live_cnt), 64'd2);

`ifdef MATRIX_BANK_LOOKUP_EN
        @(negedge clk);
        q_m = 3'd2; q_n = 3'd3; q_idx = 1'b0;
        @(posedge clk); #1;
        check("lookup young hit", 64'(q_hit), 64'd1);
        check("lookup young base", 64'(q_base), 64'd0);
        check("lookup cnt", 64'(q_cnt), 64'd2);
        @(negedge clk);
        q_idx = 1'b1;
        @(posedge clk); #1;
        check("lookup older hit", 64'(q_hit), 64'd1);
        check("lookup older base", 64'(q_base), 64'd25);
        @(negedge clk);
        q_m = 3'd5; q_n = 3'd5; q_idx = 1'b0;
        @(posedge clk); #1;
        check("lookup absent hit", 64'(q_hit), 64'd0);
        check("lookup absent base", 64'(q_base), 64'd0);
        check("lookup absent cnt", 64'(q_cnt), 64'd0);
`endif

        // Illegal dimensions, including one whose low bits look legal.
        illegal_req(32'd6, 32'd2, "t2 m=6");
        illegal_req(32'd0, 32'd2, "t2 m=0");
        illegal_req(32'd2, 32'h0000_0103, "t2 n wide");

        // Element RAM: write/read, read-during-write, out of range.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 8'd30; wr_data = 32'd7;
        @(negedge clk);
        wr_en = 1'b0; rd_addr = 8'd30;
        @(posedge clk); #1;
        check("t5 read 30", 64'(rd_data), 64'd7);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 8'd30; wr_data = 32'd9; rd_addr = 8'd30;
        @(posedge clk); #1;
        check("t5 collision old data", 64'(rd_data), 64'd7);
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk); #1;
        check("t5 read after collision", 64'(rd_data), 64'd9);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 8'd250; wr_data = 32'hDEAD_BEEF; rd_addr = 8'd250;
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk); #1;
        check("t5 read 250", 64'(rd_data), 64'd0);
        @(negedge clk);
        rd_addr = 8'd30;
        @(posedge clk); #1;
        check("t5 addr 30 intact", 64'(rd_data), 64'd9);

        // Reset in the middle of a scan.
        @(negedge clk);
        req_valid = 1'b1; req_m = 32'd2; req_n = 32'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("t6 live during reset", 64'(live_cnt), 64'd0);
        check("t6 ready during reset", 64'(alloc_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_pulses(20, cnt, base);
        check("t6 no pulse", 64'(cnt), 64'd0);
        check("t6 live after reset", 64'(live_cnt), 64'd0);
        do_alloc(32'd2, 32'd3, "t6 realloc", base);
        check("t6 realloc base", 64'(base), 64'd0);
        check("t6 realloc live", 64'(live_cnt), 64'd1);

        // Fill every slot with distinct dims, then evict the oldest overall.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            do_alloc(32'(1 + k / 5), 32'(1 + k % 5), "t3 fill", base);
            check("t3 fill base", 64'(base), 64'(k * 25));
        end
        check("t3 full live", 64'(live_cnt), 64'd10);
        do_alloc(32'd5, 32'd5, "t3 evict", base);
        check("t3 evict base", 64'(base), 64'd0);
        check("t3 evict live", 64'(live_cnt), 64'd10);

        // Level request held: exactly one allocation until it drops.
        @(negedge clk);
        req_valid = 1'b1; req_m = 32'd1; req_n = 32'd1;
        count_pulses(40, cnt, base);
        check("t4 held pulses", 64'(cnt), 64'd1);
        check("t4 held base", 64'(base), 64'd25);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        count_pulses(20, cnt, base);
        check("t4 reraise pulses", 64'(cnt), 64'd1);
        check("t4 reraise base", 64'(base), 64'd50);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
